// File: rtl/fetch_pc_npc_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int PC_INC   = 4;
  localparam int PC_MAX_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_HOLD,
    PC_LOAD,
    PC_STEP
  } pc_mode_t;

  // pc is stored at the widest supported width; the fetch unit uses the low AW bits.
  typedef struct packed {
    logic [INSTR_W-1:0]  instr;
    logic [PC_MAX_W-1:0] pc;
    logic                valid;
  } ifid_t;

endpackage

// File: rtl/fetch_pc_npc_unit_if.sv
// Fetch-unit bus: control from the hazard/branch logic, ROM port and IF/ID outputs.
interface fetch_pc_npc_unit_if #(
  parameter int AW    = 9,
  parameter int CNT_W = 16
);
  logic             stall_if;
  logic             flush_ifid;
  logic             redirect_valid;
  logic [AW-1:0]    redirect_ta;
  logic [AW-1:0]    imem_addr;
  logic [31:0]      imem_rdata;
  logic [AW-1:0]    pc;
  logic [AW-1:0]    npc;
  logic [31:0]      ifid_instr;
  logic [AW-1:0]    ifid_pc;
  logic             ifid_valid;
  logic             misalign_err;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output stall_if, flush_ifid, redirect_valid, redirect_ta, imem_rdata,
    input  imem_addr, pc, npc, ifid_instr, ifid_pc, ifid_valid, misalign_err, fetch_count
  );

  modport slave (
    input  stall_if, flush_ifid, redirect_valid, redirect_ta, imem_rdata,
    output imem_addr, pc, npc, ifid_instr, ifid_pc, ifid_valid, misalign_err, fetch_count
  );
endinterface

// File: rtl/fetch_pc_npc_unit_pc_npc_pair_reg.sv
// PC/nPC register pair with hold, load-target and increment modes.
module pc_npc_pair_reg
  import fetch_pkg::*;
#(
  parameter int AW           = 9,
  parameter int RESET_VECTOR = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  pc_mode_t      mode,
  input  logic [AW-1:0] target,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] npc
);

  localparam logic [AW-1:0] RV   = AW'(RESET_VECTOR);
  localparam logic [AW-1:0] STEP = AW'(PC_INC);

  // All arithmetic wraps modulo 2^AW, so npc rolls from 2^AW-4 to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RV;
      npc <= RV + STEP;
    end else begin
      case (mode)
        PC_LOAD: begin
          pc  <= target;
          npc <= target + STEP;
        end
        PC_STEP: begin
          pc  <= npc;
          npc <= npc + STEP;
        end
        default: begin
          pc  <= pc;
          npc <= npc;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_pc_npc_unit.sv
// Instruction-fetch front end: PC/nPC pair, redirect/stall/flush priority,
// IF/ID register, sticky misaligned-target flag and saturating fetch counter.
module fetch_pc_npc_unit
  import fetch_pkg::*;
#(
  parameter int AW           = 9,
  parameter int RESET_VECTOR = 0,
  parameter int DELAY_SLOT   = 1,
  parameter int CNT_W        = 16
) (
  input logic                clk,
  input logic                rst_n,
  fetch_pc_npc_unit_if.slave bus
);

  if (RESET_VECTOR % 4 != 0) begin : g_bad_reset_vector
    $error("RESET_VECTOR must be a multiple of 4");
  end

  pc_mode_t         mode;
  logic [AW-1:0]    target;
  logic [AW-1:0]    pc;
  logic [AW-1:0]    npc;
  ifid_t            ifid_q;
  ifid_t            ifid_d;
  logic             err_q;
  logic             err_set;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_q;
  logic             unused_pc_bits;

  assign target = {bus.redirect_ta[AW-1:2], 2'b00};

  pc_npc_pair_reg #(
    .AW          (AW),
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_pair (
    .clk   (clk),
    .rst_n (rst_n),
    .mode  (mode),
    .target(target),
    .pc    (pc),
    .npc   (npc)
  );

  // Stall freezes everything (redirect is re-presented later); flush beats capture.
  always_comb begin
    mode    = PC_HOLD;
    ifid_d  = ifid_q;
    err_set = 1'b0;
    cnt_en  = 1'b0;
    if (bus.stall_if) begin
      if (bus.flush_ifid) begin
        ifid_d = '0;
      end
    end else begin
      mode         = bus.redirect_valid ? PC_LOAD : PC_STEP;
      err_set      = bus.redirect_valid && (bus.redirect_ta[1:0] != 2'b00);
      ifid_d.pc    = PC_MAX_W'(pc);
      ifid_d.instr = bus.imem_rdata;
      ifid_d.valid = 1'b1;
      if (bus.flush_ifid || (bus.redirect_valid && DELAY_SLOT == 0)) begin
        ifid_d.instr = NOP_INSTR;
        ifid_d.valid = 1'b0;
      end
      cnt_en = ifid_d.valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      ifid_q <= ifid_d;
      err_q  <= err_q | err_set;
      if (cnt_en && cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign unused_pc_bits   = ^ifid_q.pc;

  assign bus.imem_addr    = pc;
  assign bus.pc           = pc;
  assign bus.npc          = npc;
  assign bus.ifid_instr   = ifid_q.instr;
  assign bus.ifid_pc      = ifid_q.pc[AW-1:0];
  assign bus.ifid_valid   = ifid_q.valid;
  assign bus.misalign_err = err_q;
  assign bus.fetch_count  = cnt_q;

endmodule

// File: tb/tb_fetch_pc_npc_unit.sv
// Bench for fetch_pc_npc_unit: three instances (delay slot, squash, 2-bit counter)
// share one stimulus stream and are compared every cycle against a behavioural model.
module tb_fetch_pc_npc_unit;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stall_if;
  logic       flush_ifid;
  logic       redirect_valid;
  logic [8:0] redirect_ta;
  logic       check_en;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_pc_npc_unit_if #(.AW(9), .CNT_W(16)) if0 ();
  fetch_pc_npc_unit_if #(.AW(9), .CNT_W(16)) if1 ();
  fetch_pc_npc_unit_if #(.AW(9), .CNT_W(2))  if2 ();

  function automatic logic [31:0] rom(input logic [8:0] addr);
    return 32'hC0DE_0000 | {23'd0, addr};
  endfunction

  assign if0.stall_if = stall_if;        assign if1.stall_if = stall_if;        assign if2.stall_if = stall_if;
  assign if0.flush_ifid = flush_ifid;    assign if1.flush_ifid = flush_ifid;    assign if2.flush_ifid = flush_ifid;
  assign if0.redirect_valid = redirect_valid;
  assign if1.redirect_valid = redirect_valid;
  assign if2.redirect_valid = redirect_valid;
  assign if0.redirect_ta = redirect_ta;  assign if1.redirect_ta = redirect_ta;  assign if2.redirect_ta = redirect_ta;
  assign if0.imem_rdata = rom(if0.imem_addr);
  assign if1.imem_rdata = rom(if1.imem_addr);
  assign if2.imem_rdata = rom(if2.imem_addr);

  fetch_pc_npc_unit #(.AW(9), .RESET_VECTOR(0), .DELAY_SLOT(1), .CNT_W(16))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  fetch_pc_npc_unit #(.AW(9), .RESET_VECTOR(0), .DELAY_SLOT(0), .CNT_W(16))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  fetch_pc_npc_unit #(.AW(9), .RESET_VECTOR(0), .DELAY_SLOT(1), .CNT_W(2))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic [8:0]  o_addr[N], o_pc[N], o_npc[N], o_ifpc[N];
  logic [31:0] o_instr[N];
  logic        o_valid[N], o_err[N];
  logic [15:0] o_cnt[N];

  assign o_addr[0] = if0.imem_addr;  assign o_addr[1] = if1.imem_addr;  assign o_addr[2] = if2.imem_addr;
  assign o_pc[0] = if0.pc;           assign o_pc[1] = if1.pc;           assign o_pc[2] = if2.pc;
  assign o_npc[0] = if0.npc;         assign o_npc[1] = if1.npc;         assign o_npc[2] = if2.npc;
  assign o_ifpc[0] = if0.ifid_pc;    assign o_ifpc[1] = if1.ifid_pc;    assign o_ifpc[2] = if2.ifid_pc;
  assign o_instr[0] = if0.ifid_instr; assign o_instr[1] = if1.ifid_instr; assign o_instr[2] = if2.ifid_instr;
  assign o_valid[0] = if0.ifid_valid; assign o_valid[1] = if1.ifid_valid; assign o_valid[2] = if2.ifid_valid;
  assign o_err[0] = if0.misalign_err; assign o_err[1] = if1.misalign_err; assign o_err[2] = if2.misalign_err;
  assign o_cnt[0] = if0.fetch_count;  assign o_cnt[1] = if1.fetch_count;
  assign o_cnt[2] = {14'd0, if2.fetch_count};

  // Model: per instance, the fetch address, the IF/ID contents and counters as plain integers.
  int          delay_slot[N] = '{1, 0, 1};
  int          cnt_max[N]    = '{65535, 65535, 3};
  int          m_pc[N];
  logic [31:0] m_instr[N];
  int          m_ifpc[N];
  int          m_valid[N];
  int          m_err[N];
  int          m_cnt[N];

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < N; k++) begin
      if (!rst_n) begin
        m_pc[k] = 0; m_instr[k] = 0; m_ifpc[k] = 0; m_valid[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
      end else if (stall_if) begin
        if (flush_ifid) begin
          m_instr[k] = 0; m_ifpc[k] = 0; m_valid[k] = 0;
        end
      end else begin
        m_ifpc[k]  = m_pc[k];
        m_valid[k] = (!flush_ifid && (!redirect_valid || delay_slot[k] == 1)) ? 1 : 0;
        m_instr[k] = m_valid[k] ? rom(m_pc[k][8:0]) : 32'd0;
        if (m_valid[k] == 1 && m_cnt[k] < cnt_max[k]) m_cnt[k] = m_cnt[k] + 1;
        if (redirect_valid) begin
          m_pc[k] = int'(redirect_ta) / 4 * 4;
          if (int'(redirect_ta) % 4 != 0) m_err[k] = 1;
        end else begin
          m_pc[k] = (m_pc[k] + 4) % 512;
        end
      end
    end
  end

  task automatic check_value(input string name, input int k,
                             input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s dut%0d actual=%h expected=%h at %0t", name, k, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && check_en) begin
      for (int k = 0; k < N; k++) begin
        check_value("imem_addr", k, {23'd0, o_addr[k]}, m_pc[k]);
        check_value("pc", k, {23'd0, o_pc[k]}, m_pc[k]);
        check_value("npc", k, {23'd0, o_npc[k]}, (m_pc[k] + 4) % 512);
        check_value("ifid_instr", k, o_instr[k], m_instr[k]);
        check_value("ifid_pc", k, {23'd0, o_ifpc[k]}, m_ifpc[k]);
        check_value("ifid_valid", k, {31'd0, o_valid[k]}, m_valid[k]);
        check_value("misalign_err", k, {31'd0, o_err[k]}, m_err[k]);
        check_value("fetch_count", k, {16'd0, o_cnt[k]}, m_cnt[k]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    for (int k = 0; k < N; k++) begin
      check_value({tag, "_pc"}, k, {23'd0, o_pc[k]}, 32'h0);
      check_value({tag, "_npc"}, k, {23'd0, o_npc[k]}, 32'h4);
      check_value({tag, "_instr"}, k, o_instr[k], 32'h0);
      check_value({tag, "_ifpc"}, k, {23'd0, o_ifpc[k]}, 32'h0);
      check_value({tag, "_valid"}, k, {31'd0, o_valid[k]}, 32'h0);
      check_value({tag, "_err"}, k, {31'd0, o_err[k]}, 32'h0);
      check_value({tag, "_cnt"}, k, {16'd0, o_cnt[k]}, 32'h0);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall_if = 1'b0; flush_ifid = 1'b0;
    redirect_valid = 1'b0; redirect_ta = '0; check_en = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");
    rst_n = 1'b1; check_en = 1'b1;

    // Sequential fetch from 0.
    repeat (4) tick();
    check_value("seq_pc", 0, {23'd0, o_pc[0]}, 32'h10);
    check_value("seq_ifpc", 0, {23'd0, o_ifpc[0]}, 32'h0C);
    check_value("seq_instr", 0, o_instr[0], 32'hC0DE_000C);
    check_value("seq_cnt", 0, {16'd0, o_cnt[0]}, 32'd4);
    check_value("sat_cnt4", 2, {16'd0, o_cnt[2]}, 32'd3);

    // Redirect to 0x40 while pc=0x10.
    redirect_valid = 1'b1; redirect_ta = 9'h040;
    tick();
    redirect_valid = 1'b0;
    check_value("ds_ifpc", 0, {23'd0, o_ifpc[0]}, 32'h10);
    check_value("ds_valid", 0, {31'd0, o_valid[0]}, 32'h1);
    check_value("ds_pc", 0, {23'd0, o_pc[0]}, 32'h40);
    check_value("ds_npc", 0, {23'd0, o_npc[0]}, 32'h44);
    check_value("sq_valid", 1, {31'd0, o_valid[1]}, 32'h0);
    check_value("sq_instr", 1, o_instr[1], 32'h0);
    check_value("sq_pc", 1, {23'd0, o_pc[1]}, 32'h40);
    check_value("sq_cnt", 1, {16'd0, o_cnt[1]}, 32'd4);

    // Three stalled edges; redirect and flush on the second.
    stall_if = 1'b1;
    tick();
    check_value("stall1_valid", 0, {31'd0, o_valid[0]}, 32'h1);
    check_value("stall1_ifpc", 0, {23'd0, o_ifpc[0]}, 32'h10);
    redirect_valid = 1'b1; redirect_ta = 9'h080; flush_ifid = 1'b1;
    tick();
    redirect_valid = 1'b0; flush_ifid = 1'b0;
    check_value("stall2_valid", 0, {31'd0, o_valid[0]}, 32'h0);
    check_value("stall2_pc", 0, {23'd0, o_pc[0]}, 32'h40);
    check_value("stall2_npc", 0, {23'd0, o_npc[0]}, 32'h44);
    tick();
    check_value("stall3_pc", 0, {23'd0, o_pc[0]}, 32'h40);
    check_value("stall3_cnt", 0, {16'd0, o_cnt[0]}, 32'd5);
    stall_if = 1'b0;
    tick();
    check_value("resume_pc", 0, {23'd0, o_pc[0]}, 32'h44);
    check_value("resume_ifpc", 0, {23'd0, o_ifpc[0]}, 32'h40);
    check_value("resume_cnt", 1, {16'd0, o_cnt[1]}, 32'd5);

    // Misaligned target near the top of the address space.
    redirect_valid = 1'b1; redirect_ta = 9'h1FE;
    tick();
    redirect_valid = 1'b0;
    check_value("mis_pc", 0, {23'd0, o_pc[0]}, 32'h1FC);
    check_value("mis_npc", 0, {23'd0, o_npc[0]}, 32'h000);
    check_value("mis_err", 0, {31'd0, o_err[0]}, 32'h1);
    tick();
    check_value("wrap_pc", 0, {23'd0, o_pc[0]}, 32'h000);
    check_value("wrap_ifpc", 0, {23'd0, o_ifpc[0]}, 32'h1FC);
    tick();
    flush_ifid = 1'b1;
    tick();
    flush_ifid = 1'b0;
    check_value("flush_pc", 0, {23'd0, o_pc[0]}, 32'h8);
    check_value("flush_valid", 0, {31'd0, o_valid[0]}, 32'h0);
    check_value("flush_cnt", 0, {16'd0, o_cnt[0]}, 32'd9);
    check_value("sticky_err", 1, {31'd0, o_err[1]}, 32'h1);

    // Asynchronous reset in the middle of a redirect cycle.
    redirect_valid = 1'b1; redirect_ta = 9'h100;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async");
    redirect_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (5) tick();
    check_value("sat_cnt5", 2, {16'd0, o_cnt[2]}, 32'd3);
    check_value("post_cnt", 0, {16'd0, o_cnt[0]}, 32'd5);
    check_value("post_pc", 0, {23'd0, o_pc[0]}, 32'h14);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
